// File: rtl/bcd_countdown_timer_if.sv
// bcd_countdown_timer_if: preset/control inputs and count/status outputs of the BCD countdown timer.
interface bcd_countdown_timer_if #(
    parameter int NUM_DIGITS = 4
);
    logic [4*NUM_DIGITS-1:0] data;
    logic                    loadn;
    logic                    en;
    logic                    wrap;
    logic [4*NUM_DIGITS-1:0] digits;
    logic                    zero;
    logic                    tc;
    logic                    done;
    modport master (output data, loadn, en, wrap, input digits, zero, tc, done);
    modport slave  (input data, loadn, en, wrap, output digits, zero, tc, done);
endinterface

// File: rtl/bcd_countdown_timer.sv
// bcd_countdown_timer: cascaded BCD down-counter with per-digit moduli, load clamping,
// saturate-or-wrap at zero and a registered done pulse.
module bcd_countdown_timer #(
    parameter int          NUM_DIGITS = 4,
    parameter logic [31:0] DIGIT_MAX  = 32'h0000_5959
) (
    input  logic                  clk,
    input  logic                  clrn,
    bcd_countdown_timer_if.slave  bus
);
    localparam int            W   = 4*NUM_DIGITS;
    localparam logic [W-1:0]  MAX = DIGIT_MAX[W-1:0];

    logic [W-1:0] digits_q, digits_d, dec, clamp;
    logic         done_q, done_d, zero;

    if (NUM_DIGITS < 1 || NUM_DIGITS > 8) begin : g_bad_n
        $error("bcd_countdown_timer: NUM_DIGITS must be 1..8");
    end

    for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_digit
        logic [3:0] cur, mx, din;
        logic       borrow;
        assign cur = digits_q[4*i +: 4];
        assign mx  = MAX[4*i +: 4];
        assign din = bus.data[4*i +: 4];
        // A digit steps only when every lower digit is already zero.
        if (i == 0) begin : g_b0
            assign borrow = 1'b1;
        end else begin : g_bn
            assign borrow = digits_q[4*i-1:0] == '0;
        end
        assign dec[4*i +: 4]   = !borrow ? cur : cur == 4'd0 ? mx : cur - 4'd1;
        assign clamp[4*i +: 4] = din > mx ? mx : din;
        if (DIGIT_MAX[4*i +: 4] > 4'd9) begin : g_bad_max
            $error("bcd_countdown_timer: DIGIT_MAX nibble above 9");
        end
    end

    assign zero = digits_q == '0;

    always_comb begin
        digits_d = !bus.loadn ? clamp : !bus.en ? digits_q : !zero ? dec : bus.wrap ? MAX : '0;
        done_d   = bus.loadn && bus.en && !zero && dec == '0;
    end

    always_ff @(posedge clk) begin
        if (!clrn) begin
            digits_q <= '0;
            done_q   <= 1'b0;
        end else begin
            digits_q <= digits_d;
            done_q   <= done_d;
        end
    end

    assign bus.digits = digits_q;
    assign bus.zero   = zero;
    assign bus.tc     = zero && bus.en;
    assign bus.done   = done_q;
endmodule

// File: tb/tb_bcd_countdown_timer.sv
// tb_bcd_countdown_timer: directed plan plus random traffic, checked against a
// mixed-radix integer model of the countdown.
module tb_bcd_countdown_timer;
    localparam int          N   = 4;
    localparam logic [31:0] DMX = 32'h0000_5959;

    logic clk = 1'b0;
    logic clrn;
    int   total = 0;
    int   bad   = 0;
    int   m_val;
    bit   m_done;
    int   max_total;

    always #5 clk = ~clk;

    bcd_countdown_timer_if #(.NUM_DIGITS(N)) ifc ();

    bcd_countdown_timer #(.NUM_DIGITS(N), .DIGIT_MAX(DMX)) dut (
        .clk  (clk),
        .clrn (clrn),
        .bus  (ifc)
    );

    function automatic int radix(input int i);
        logic [31:0] m;
        m = DMX;
        return int'(m[4*i +: 4]) + 1;
    endfunction

    // Load value as an integer count of ticks, each nibble clamped to its maximum.
    function automatic int load_val(input logic [15:0] d);
        int v = 0;
        int mul = 1;
        for (int i = 0; i < N; i++) begin
            int nib = int'(d[4*i +: 4]);
            if (nib > radix(i) - 1) nib = radix(i) - 1;
            v += nib * mul;
            mul *= radix(i);
        end
        return v;
    endfunction

    function automatic logic [15:0] to_bcd(input int v);
        logic [15:0] r = '0;
        for (int i = 0; i < N; i++) begin
            r[4*i +: 4] = 4'(v % radix(i));
            v = v / radix(i);
        end
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step(input bit c, input bit l, input bit e, input bit w, input logic [15:0] d);
        clrn = c; ifc.loadn = l; ifc.en = e; ifc.wrap = w; ifc.data = d;
        @(posedge clk);
        if (!c) begin
            m_val = 0; m_done = 0;
        end else if (!l) begin
            m_val = load_val(d); m_done = 0;
        end else if (e) begin
            if (m_val == 0) begin
                m_val = w ? max_total : 0; m_done = 0;
            end else begin
                m_val--; m_done = (m_val == 0);
            end
        end else begin
            m_done = 0;
        end
        @(negedge clk);
        chk("digits", 32'(ifc.digits), 32'(to_bcd(m_val)));
        chk("zero",   32'(ifc.zero),   32'(m_val == 0));
        chk("tc",     32'(ifc.tc),     32'(m_val == 0 && e));
        chk("done",   32'(ifc.done),   32'(m_done));
    endtask

    initial begin
        max_total = 1;
        for (int i = 0; i < N; i++) max_total *= radix(i);
        max_total--;
        m_val = 0; m_done = 0;
        clrn = 1'b0; ifc.loadn = 1'b1; ifc.en = 1'b0; ifc.wrap = 1'b0; ifc.data = '0;
        @(negedge clk);
        step(0, 1, 0, 0, 16'h0000);
        chk("rst_digits", 32'(ifc.digits), 32'h0000);
        chk("rst_done", 32'(ifc.done), 0);
        ifc.en = 1'b1;
        #1 chk("rst_tc_en", 32'(ifc.tc), 1);
        ifc.en = 1'b0;
        #1 chk("rst_tc_idle", 32'(ifc.tc), 0);
        step(1, 0, 0, 0, 16'h1000);
        step(1, 1, 1, 0, 16'h0000);
        chk("borrow_1000", 32'(ifc.digits), 32'h0959);
        step(1, 1, 1, 0, 16'h0000);
        chk("dec_0959", 32'(ifc.digits), 32'h0958);
        step(1, 0, 0, 0, 16'h0100);
        step(1, 1, 1, 0, 16'h0000);
        chk("borrow_0100", 32'(ifc.digits), 32'h0059);
        step(1, 0, 0, 0, 16'h0002);
        step(1, 1, 1, 0, 16'h0000);
        chk("cd_0001", 32'(ifc.digits), 32'h0001);
        step(1, 1, 1, 0, 16'h0000);
        chk("cd_done", 32'(ifc.done), 1);
        step(1, 1, 1, 0, 16'h0000);
        chk("hold_nodone", 32'(ifc.done), 0);
        step(1, 1, 1, 0, 16'h0000);
        chk("hold_zero", 32'(ifc.digits), 32'h0000);
        step(1, 0, 0, 1, 16'h0000);
        chk("load0_nodone", 32'(ifc.done), 0);
        step(1, 1, 1, 1, 16'h0000);
        chk("wrap_5959", 32'(ifc.digits), 32'h5959);
        chk("wrap_nodone", 32'(ifc.done), 0);
        step(1, 1, 1, 1, 16'h0000);
        chk("wrap_5958", 32'(ifc.digits), 32'h5958);
        step(1, 0, 1, 0, 16'hFC7C);
        chk("clamp", 32'(ifc.digits), 32'h5959);
        step(0, 0, 1, 0, 16'h1234);
        chk("rst_over_load", 32'(ifc.digits), 32'h0000);
        step(1, 0, 0, 0, 16'h0130);
        for (int k = 0; k < 5; k++) step(1, 1, 1, 0, 16'h0000);
        chk("mid_0125", 32'(ifc.digits), 32'h0125);
        step(0, 1, 1, 0, 16'h0000);
        chk("mid_rst", 32'(ifc.digits), 32'h0000);
        chk("mid_rst_done", 32'(ifc.done), 0);
        step(1, 1, 1, 0, 16'h0000);
        chk("post_rst_hold", 32'(ifc.digits), 32'h0000);
        for (int k = 0; k < 600; k++) begin
            logic [15:0] d;
            d = ($urandom % 3 == 0) ? 16'($urandom % 4) : 16'($urandom);
            step($urandom % 25 != 0, $urandom % 10 != 0, $urandom % 4 != 0, 1'($urandom), d);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/bcd_countdown_timer.md
Name: bcd_countdown_timer

Overview:
- Multi-digit cascaded BCD down-counter for the microwave timer. Generalises the single mod-6 tens digit into N digits, each with its own modulus, giving a full MM:SS style countdown.
- Adds saturate-or-wrap mode, per-digit load clamping and a registered "done" pulse.
- Sits between the keypad/load logic (preset time) and the display/magnetron control (zero, done).

Parameters:
- NUM_DIGITS, 4, number of BCD digits; digit 0 is least significant; legal range 1..8.
- DIGIT_MAX, 32'h0000_5959, packed 4 bits per digit; nibble i = maximum value of digit i (0..9). Default gives sec ones 9, sec tens 5, min ones 9, min tens 5.

Ports:
- clk  input  1  rising-edge clock.
- clrn  input  1  synchronous active-low reset; clears all digits.
- data  input  4*NUM_DIGITS  preset value, nibble i for digit i.
- loadn  input  1  synchronous active-low load.
- en  input  1  count enable, active high; one decrement per enabled clock.
- wrap  input  1  1 = at all-zero, next enabled clock reloads all digits to DIGIT_MAX; 0 = hold at zero.
- digits  output  4*NUM_DIGITS  current count, nibble i = digit i.
- zero  output  1  combinational; 1 when every digit is 0.
- tc  output  1  combinational; zero && en.
- done  output  1  registered one-cycle pulse on a decrement that reaches all-zero.

Behaviour:
- All state changes on the rising edge of clk. Priority: clrn, then loadn, then en.
- Reset (clrn=0): digits=0 and done=0 on the next edge. Reset overrides a simultaneous load or count, including mid-countdown.
- Load (loadn=0, clrn=1): digit i <= data nibble i, clamped to DIGIT_MAX[i] if greater (e.g. 4'hC into a max-5 digit loads 5). Load overrides en. done=0 in the load cycle.
- Count (en=1, loadn=1, clrn=1, count not all-zero):
  - Digit 0 decrements.
  - Digit i>0 decrements only when all lower digits are 0 (borrow).
  - Any digit that is 0 and receives a borrow reloads to DIGIT_MAX[i].
  - Example: 10:00 -> 09:59.
- Count from all-zero:
  - wrap=1: all digits <= DIGIT_MAX (00:00 -> 59:59).
  - wrap=0: hold at 0.
- Idle (en=0, loadn=1, clrn=1): hold.
- done: 1 for exactly one cycle after an edge where the count went from nonzero to all-zero by decrement. It is not asserted by reset, by a load of zero, or while holding at zero.
- zero and tc follow the registered digits combinationally. tc is usable as a borrow/enable into a further cascaded stage.
- Digit values never exceed DIGIT_MAX[i] under any input sequence after reset.
- Latency: one clock from load or en to the digits update.
- Width rules:
  - Decrement is 4-bit, with no binary wrap (never produces 4'hF).
  - DIGIT_MAX nibbles above 9 are a parameter error; the implementation flags them with an elaboration-time check.
- No initial blocks are relied on. The state is undefined until the first clrn=0 edge. The bench always resets first.

Test Plan:
- Reset then idle: clrn=0 for 1 cycle, en=0 -> digits=16'h0000, zero=1, tc=0, done=0; with en=1 -> tc=1.
- Load and borrow: load 16'h1000, en=1 for 1 cycle -> 16'h0959; 1 more -> 16'h0958; load 16'h0100, 1 cycle -> 16'h0059.
- Countdown to zero, wrap=0: load 16'h0002, en=1 for 4 cycles -> 0001, 0000, 0000, 0000; done=1 only in the cycle digits first read 0000; zero=1 thereafter.
- Wrap mode: load 16'h0000, wrap=1, en=1 for 1 cycle -> 16'h5959, done stays 0; next cycle -> 16'h5958.
- Clamp and priority: loadn=0, en=1, data=16'hFC7C -> digits=16'h5959 (en ignored); then clrn=0 with loadn=0 in the same cycle -> 16'h0000.
- Reset mid-operation: load 16'h0130, en=1 for 5 cycles (-> 16'h0125), then clrn=0 for 1 cycle with en=1 -> 16'h0000, done=0; release clrn with wrap=0 -> holds 0000.
